// File: rtl/toggle_gen_pkg.sv
// Shared definitions for the toggle burst generator: state encoding and default widths.
package toggle_gen_pkg;

  localparam int DEF_CNT_W = 4;
  localparam int DEF_DIV_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/toggle_burst_gen_if.sv
// Controller-facing bundle of the toggle burst generator: start/done handshake,
// burst programming, abort/clear controls and the generated line with its counters.
interface toggle_burst_gen_if
  import toggle_gen_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int DIV_W = DEF_DIV_W
);

  logic             start;
  logic [CNT_W-1:0] count;
  logic [DIV_W-1:0] half_period;
  logic             abort;
  logic             clear;
  logic             tog_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] edges_sent;

  // The test controller drives the requests and watches the generator.
  modport master (
    output start, count, half_period, abort, clear,
    input  tog_out, busy, done, edges_sent
  );

  // The generator consumes the requests and drives the line and status.
  modport slave (
    input  start, count, half_period, abort, clear,
    output tog_out, busy, done, edges_sent
  );

endinterface

// File: rtl/toggle_gen_div.sv
// Reloadable down-counter that paces toggles; zero marks the edge a toggle is due.
module toggle_gen_div #(
  parameter int DIV_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [DIV_W-1:0] load_value,
  input  logic             enable,
  output logic             zero
);

  logic [DIV_W-1:0] cnt_q;

  // Load takes precedence; otherwise count down and rest at zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_value;
    end else if (enable && (cnt_q != '0)) begin
      cnt_q <= cnt_q - DIV_W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/toggle_burst_gen.sv
// Drives a programmable burst of toggles at a programmable spacing and keeps a
// wrapping count of the toggles sent so a downstream edge counter can be checked.
module toggle_burst_gen
  import toggle_gen_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic               clock,
  input  logic               reset_n,
  toggle_burst_gen_if.slave  bus
);

  state_t           state;
  state_t           next_state;
  logic             tog_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] edges_q;
  logic [CNT_W-1:0] remaining_q;
  logic [DIV_W-1:0] half_period_q;

  logic             accept;
  logic             do_toggle;
  logic             do_clear;
  logic             div_load;
  logic [DIV_W-1:0] div_load_value;
  logic             div_enable;
  logic             div_zero;

  // Spacing counter: loaded with the requested spacing on accept, reloaded from
  // the latched copy after every toggle so later changes on the bus do not matter.
  toggle_gen_div #(
    .DIV_W (DIV_W)
  ) u_div (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (div_load),
    .load_value (div_load_value),
    .enable     (div_enable),
    .zero       (div_zero)
  );

  assign div_enable = (state == RUN) && !bus.abort;

  // Next-state and datapath strobes; abort beats a toggle due on the same edge.
  always_comb begin
    next_state     = state;
    accept         = 1'b0;
    do_toggle      = 1'b0;
    do_clear       = 1'b0;
    div_load       = 1'b0;
    div_load_value = half_period_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.count != '0) begin
            next_state     = RUN;
            accept         = 1'b1;
            div_load       = 1'b1;
            div_load_value = bus.half_period;
          end else begin
            next_state = DONE;
          end
        end else if (bus.clear) begin
          do_clear = 1'b1;
        end
      end
      RUN: begin
        if (bus.abort) begin
          next_state = IDLE;
        end else if (div_zero) begin
          do_toggle = 1'b1;
          div_load  = 1'b1;
          if (remaining_q == CNT_W'(1)) begin
            next_state = DONE;
          end
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Burst bookkeeping, the toggle line and registered status flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tog_q         <= 1'b0;
      edges_q       <= '0;
      remaining_q   <= '0;
      half_period_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      if (accept) begin
        remaining_q   <= bus.count;
        half_period_q <= bus.half_period;
      end
      if (do_toggle) begin
        tog_q       <= ~tog_q;
        edges_q     <= edges_q + CNT_W'(1);
        remaining_q <= remaining_q - CNT_W'(1);
      end
      if (do_clear) begin
        tog_q   <= 1'b0;
        edges_q <= '0;
      end
      busy_q <= (next_state != IDLE);
      done_q <= (next_state == DONE);
    end
  end

  assign bus.tog_out    = tog_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.edges_sent = edges_q;

endmodule

// File: tb/tb_toggle_burst_gen.sv
// Directed bench for toggle_burst_gen: inputs change on the falling edge,
// outputs are observed on the falling edge after each rising edge.
module tb_toggle_burst_gen;

  localparam int CNT_W = 4;
  localparam int DIV_W = 4;

  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  toggle_burst_gen_if #(.CNT_W(CNT_W), .DIV_W(DIV_W)) bus ();

  toggle_burst_gen #(.CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++; if (bus.tog_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_tog_out got %0b expected 0", bus.tog_out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %0b expected 0", bus.done); end
    checks++; if (bus.edges_sent !== 4'd0) begin errors++; $display("[TB] FAIL reset_edges got %0d expected 0", bus.edges_sent); end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy got %0b expected 0", bus.busy); end
  endtask

  task automatic test_burst_basic();
    logic       exp_tog;
    logic [3:0] exp_edges;
    bus.count = 4'd10; bus.half_period = 4'd0; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_start got %0b expected 1", bus.busy); end
    checks++; if (bus.tog_out !== 1'b0) begin errors++; $display("[TB] FAIL basic_tog_start got %0b expected 0", bus.tog_out); end
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      exp_tog   = 1'(i % 2);
      exp_edges = 4'(i);
      checks++; if (bus.tog_out !== exp_tog) begin errors++; $display("[TB] FAIL basic_tog step %0d got %0b expected %0b", i, bus.tog_out, exp_tog); end
      checks++; if (bus.edges_sent !== exp_edges) begin errors++; $display("[TB] FAIL basic_edges step %0d got %0d expected %0d", i, bus.edges_sent, exp_edges); end
      checks++; if (bus.done !== (i == 10)) begin errors++; $display("[TB] FAIL basic_done step %0d got %0b expected %0b", i, bus.done, (i == 10)); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy step %0d got %0b expected 1", i, bus.busy); end
    end
    @(negedge clock);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_end got %0b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_end got %0b expected 0", bus.done); end
    checks++; if (bus.edges_sent !== 4'd10) begin errors++; $display("[TB] FAIL basic_edges_end got %0d expected 10", bus.edges_sent); end
    checks++; if (bus.tog_out !== 1'b0) begin errors++; $display("[TB] FAIL basic_tog_end got %0b expected 0", bus.tog_out); end
  endtask

  task automatic test_wrap();
    int n;
    // count=5 from edges=10, tog=0: done after 5 edges, edges=15, tog=1
    bus.count = 4'd5; bus.half_period = 4'd0; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    n = 0;
    while (bus.done !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    checks++; if (n != 5) begin errors++; $display("[TB] FAIL wrap5_latency got %0d expected 5", n); end
    checks++; if (bus.edges_sent !== 4'd15) begin errors++; $display("[TB] FAIL wrap5_edges got %0d expected 15", bus.edges_sent); end
    checks++; if (bus.tog_out !== 1'b1) begin errors++; $display("[TB] FAIL wrap5_tog got %0b expected 1", bus.tog_out); end
    @(negedge clock);
    // count=2 from edges=15: wraps to 1, tog returns to 1
    bus.count = 4'd2; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    n = 0;
    while (bus.done !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    checks++; if (n != 2) begin errors++; $display("[TB] FAIL wrap2_latency got %0d expected 2", n); end
    checks++; if (bus.edges_sent !== 4'd1) begin errors++; $display("[TB] FAIL wrap2_edges got %0d expected 1", bus.edges_sent); end
    checks++; if (bus.tog_out !== 1'b1) begin errors++; $display("[TB] FAIL wrap2_tog got %0b expected 1", bus.tog_out); end
    @(negedge clock);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL wrap2_busy_end got %0b expected 0", bus.busy); end
  endtask

  task automatic test_spacing();
    int         ntog;
    logic       exp_tog;
    logic [3:0] exp_edges;
    // starts from tog=1, edges=1; toggles on k+3, k+6, k+9
    bus.count = 4'd3; bus.half_period = 4'd2; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clock);
      ntog      = (j / 3 > 3) ? 3 : j / 3;
      exp_tog   = 1'b1 ^ 1'(ntog % 2);
      exp_edges = 4'(1 + ntog);
      checks++; if (bus.tog_out !== exp_tog) begin errors++; $display("[TB] FAIL space_tog step %0d got %0b expected %0b", j, bus.tog_out, exp_tog); end
      checks++; if (bus.edges_sent !== exp_edges) begin errors++; $display("[TB] FAIL space_edges step %0d got %0d expected %0d", j, bus.edges_sent, exp_edges); end
      checks++; if (bus.done !== (j == 9)) begin errors++; $display("[TB] FAIL space_done step %0d got %0b expected %0b", j, bus.done, (j == 9)); end
      checks++; if (bus.busy !== (j <= 9)) begin errors++; $display("[TB] FAIL space_busy step %0d got %0b expected %0b", j, bus.busy, (j <= 9)); end
      if (j == 3) begin bus.start = 1'b1; bus.count = 4'd7; bus.half_period = 4'd0; end
      if (j == 4) bus.start = 1'b0;
    end
  endtask

  task automatic test_zero_count();
    // state before: tog=0, edges=4
    bus.count = 4'd0; bus.half_period = 4'd0; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    checks++; if (bus.done !== 1'b1) begin errors++; $display("[TB] FAIL zero_done got %0b expected 1", bus.done); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL zero_busy got %0b expected 1", bus.busy); end
    checks++; if (bus.edges_sent !== 4'd4) begin errors++; $display("[TB] FAIL zero_edges got %0d expected 4", bus.edges_sent); end
    checks++; if (bus.tog_out !== 1'b0) begin errors++; $display("[TB] FAIL zero_tog got %0b expected 0", bus.tog_out); end
    @(negedge clock);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL zero_done_end got %0b expected 0", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_busy_end got %0b expected 0", bus.busy); end
    checks++; if (bus.edges_sent !== 4'd4) begin errors++; $display("[TB] FAIL zero_edges_end got %0d expected 4", bus.edges_sent); end
  endtask

  task automatic test_abort_clear();
    int         ntog;
    logic [3:0] exp_edges;
    bus.clear = 1'b1;
    @(negedge clock);
    bus.clear = 1'b0;
    checks++; if (bus.edges_sent !== 4'd0) begin errors++; $display("[TB] FAIL clear_edges got %0d expected 0", bus.edges_sent); end
    checks++; if (bus.tog_out !== 1'b0) begin errors++; $display("[TB] FAIL clear_tog got %0b expected 0", bus.tog_out); end
    // count=8, spacing 2: toggles at k+2, k+4, k+6; abort lands on k+8 where a toggle is due
    bus.count = 4'd8; bus.half_period = 4'd1; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      @(negedge clock);
      ntog      = j / 2;
      exp_edges = 4'(ntog);
      checks++; if (bus.edges_sent !== exp_edges) begin errors++; $display("[TB] FAIL abort_run_edges step %0d got %0d expected %0d", j, bus.edges_sent, exp_edges); end
      checks++; if (bus.tog_out !== 1'(ntog % 2)) begin errors++; $display("[TB] FAIL abort_run_tog step %0d got %0b expected %0b", j, bus.tog_out, 1'(ntog % 2)); end
      if (j == 3) bus.clear = 1'b1;
      if (j == 4) bus.clear = 1'b0;
    end
    bus.abort = 1'b1;
    @(negedge clock);
    bus.abort = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got %0b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL abort_done got %0b expected 0", bus.done); end
    checks++; if (bus.edges_sent !== 4'd3) begin errors++; $display("[TB] FAIL abort_edges got %0d expected 3", bus.edges_sent); end
    checks++; if (bus.tog_out !== 1'b1) begin errors++; $display("[TB] FAIL abort_tog got %0b expected 1", bus.tog_out); end
    @(negedge clock);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL abort_done_after got %0b expected 0", bus.done); end
    checks++; if (bus.edges_sent !== 4'd3) begin errors++; $display("[TB] FAIL abort_edges_after got %0d expected 3", bus.edges_sent); end
    bus.clear = 1'b1;
    @(negedge clock);
    bus.clear = 1'b0;
    checks++; if (bus.edges_sent !== 4'd0) begin errors++; $display("[TB] FAIL clear2_edges got %0d expected 0", bus.edges_sent); end
    checks++; if (bus.tog_out !== 1'b0) begin errors++; $display("[TB] FAIL clear2_tog got %0b expected 0", bus.tog_out); end
  endtask

  task automatic test_async_reset();
    bus.count = 4'd5; bus.half_period = 4'd0; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (bus.edges_sent !== 4'd3) begin errors++; $display("[TB] FAIL prereset_edges got %0d expected 3", bus.edges_sent); end
    checks++; if (bus.tog_out !== 1'b1) begin errors++; $display("[TB] FAIL prereset_tog got %0b expected 1", bus.tog_out); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.tog_out !== 1'b0) begin errors++; $display("[TB] FAIL areset_tog got %0b expected 0", bus.tog_out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL areset_busy got %0b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL areset_done got %0b expected 0", bus.done); end
    checks++; if (bus.edges_sent !== 4'd0) begin errors++; $display("[TB] FAIL areset_edges got %0d expected 0", bus.edges_sent); end
    @(negedge clock);
    reset_n = 1'b1;
    bus.count = 4'd1; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL one_busy got %0b expected 1", bus.busy); end
    @(negedge clock);
    checks++; if (bus.tog_out !== 1'b1) begin errors++; $display("[TB] FAIL one_tog got %0b expected 1", bus.tog_out); end
    checks++; if (bus.edges_sent !== 4'd1) begin errors++; $display("[TB] FAIL one_edges got %0d expected 1", bus.edges_sent); end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("[TB] FAIL one_done got %0b expected 1", bus.done); end
    @(negedge clock);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL one_busy_end got %0b expected 0", bus.busy); end
    // start and clear together: start wins, nothing cleared
    bus.count = 4'd1; bus.start = 1'b1; bus.clear = 1'b1;
    @(negedge clock);
    bus.start = 1'b0; bus.clear = 1'b0;
    checks++; if (bus.edges_sent !== 4'd1) begin errors++; $display("[TB] FAIL startclr_edges got %0d expected 1", bus.edges_sent); end
    checks++; if (bus.tog_out !== 1'b1) begin errors++; $display("[TB] FAIL startclr_tog got %0b expected 1", bus.tog_out); end
    @(negedge clock);
    checks++; if (bus.edges_sent !== 4'd2) begin errors++; $display("[TB] FAIL startclr_edges_end got %0d expected 2", bus.edges_sent); end
    checks++; if (bus.tog_out !== 1'b0) begin errors++; $display("[TB] FAIL startclr_tog_end got %0b expected 0", bus.tog_out); end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("[TB] FAIL startclr_done got %0b expected 1", bus.done); end
    @(negedge clock);
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.count       = 4'd0;
    bus.half_period = 4'd0;
    bus.abort       = 1'b0;
    bus.clear       = 1'b0;
    reset_n         = 1'b0;
    test_reset();
    test_burst_basic();
    test_wrap();
    test_spacing();
    test_zero_count();
    test_abort_clear();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
